mc_control_fsm: RTL and testbench

Main control state machine for the multi-cycle RV32I core. It sequences the shared datapath (one memory, one ALU, IR/OldPC/ALUOut/Data registers) across Fetch/Decode/Execute/Memory/Writeback cycles and drives mux selects, write enables and the 2-bit ALU class code consumed by `ALU_Control` (`i_alu_ctl`). The instruction subset is lw, sw, R-type, I-type ALU, beq and jal; any other opcode traps.

---
 rtl/mc_pkg.sv | 83 ++++++++
 rtl/mc_imm_decoder.sv | 27 ++
 rtl/mc_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multi-cycle RV32I control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  localparam logic [3:0] c_st_fetch    = 4'd0;
  localparam logic [3:0] c_st_decode   = 4'd1;
  localparam logic [3:0] c_st_memadr   = 4'd2;
  localparam logic [3:0] c_st_memread  = 4'd3;
  localparam logic [3:0] c_st_memwb    = 4'd4;
  localparam logic [3:0] c_st_memwrite = 4'd5;
  localparam logic [3:0] c_st_execr    = 4'd6;
  localparam logic [3:0] c_st_aluwb    = 4'd7;
  localparam logic [3:0] c_st_execi    = 4'd8;
  localparam logic [3:0] c_st_jal      = 4'd9;
  localparam logic [3:0] c_st_beq      = 4'd10;
  localparam logic [3:0] c_st_trap     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic        pc_update;
    logic        branch;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    result_src_e result_src;
    src_a_e      src_a;
    src_b_e      src_b;
    alu_ctl_e    alu_ctl;
    logic        reg_write;
    logic        trap;
  } ctrl_t;

  // States that wait on the memory handshake when stalling is enabled.
  function automatic logic mem_wait_state(input logic [3:0] state);
    return (state == c_st_fetch) || (state == c_st_memread) ||
           (state == c_st_memwrite);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_imm_decoder.sv
// ============================================================================
// Module      : mc_imm_decoder
// Description : Opcode to immediate-format select (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_imm_decoder
  import mc_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_SW:   o_imm_src = IMM_S;
      OP_BEQ:  o_imm_src = IMM_B;
      OP_JAL:  o_imm_src = IMM_J;
      default: o_imm_src = IMM_I;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module      : mc_control_fsm
// Description : Main Moore control FSM of the multi-cycle RV32I core.
//               Optional memory stall handshake under macro MC_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_ctl,
  output logic [1:0] o_imm_src,
  output logic       o_reg_write,
  output logic       o_trap,
  output logic [3:0] o_state
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  ctrl_t      w_ctl;
  logic       w_mem_ok;
  logic       w_hold;
  logic       w_gate;

`ifdef MC_STALL_EN
  assign w_mem_ok = i_mem_ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = i_mem_ready;
  assign w_mem_ok       = 1'b1;
`endif

  assign w_hold = mem_wait_state(r_state) & ~w_mem_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_st_fetch;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = c_st_fetch;
    case (r_state)
      c_st_fetch:  w_next = c_st_decode;
      c_st_decode: begin
        case (i_op)
          OP_LW, OP_SW: w_next = c_st_memadr;
          OP_R:         w_next = c_st_execr;
          OP_I:         w_next = c_st_execi;
          OP_JAL:       w_next = c_st_jal;
          OP_BEQ:       w_next = c_st_beq;
          default:      w_next = c_st_trap;
        endcase
      end
      c_st_memadr:   w_next = (i_op == OP_LW) ? c_st_memread : c_st_memwrite;
      c_st_memread:  w_next = c_st_memwb;
      c_st_memwb:    w_next = c_st_fetch;
      c_st_memwrite: w_next = c_st_fetch;
      c_st_execr:    w_next = c_st_aluwb;
      c_st_execi:    w_next = c_st_aluwb;
      c_st_aluwb:    w_next = c_st_fetch;
      c_st_jal:      w_next = c_st_aluwb;
      c_st_beq:      w_next = c_st_fetch;
      c_st_trap:     w_next = c_st_trap;
      default:       w_next = c_st_fetch;
    endcase
    if (w_hold) begin
      w_next = r_state;
    end
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      c_st_fetch: begin
        w_ctl.ir_write   = 1'b1;
        w_ctl.src_a      = SRCA_PC;
        w_ctl.src_b      = SRCB_FOUR;
        w_ctl.alu_ctl    = ALU_ADD;
        w_ctl.result_src = RES_ALURESULT;
        w_ctl.pc_update  = 1'b1;
      end
      c_st_decode: begin
        w_ctl.src_a   = SRCA_OLDPC;
        w_ctl.src_b   = SRCB_IMM;
        w_ctl.alu_ctl = ALU_ADD;
      end
      c_st_memadr: begin
        w_ctl.src_a   = SRCA_RD1;
        w_ctl.src_b   = SRCB_IMM;
        w_ctl.alu_ctl = ALU_ADD;
      end
      c_st_memread: begin
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.adr_src    = 1'b1;
      end
      c_st_memwb: begin
        w_ctl.result_src = RES_DATA;
        w_ctl.reg_write  = 1'b1;
      end
      c_st_memwrite: begin
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.adr_src    = 1'b1;
        w_ctl.mem_write  = 1'b1;
      end
      c_st_execr: begin
        w_ctl.src_a   = SRCA_RD1;
        w_ctl.src_b   = SRCB_RD2;
        w_ctl.alu_ctl = ALU_FUNCT;
      end
      c_st_execi: begin
        w_ctl.src_a   = SRCA_RD1;
        w_ctl.src_b   = SRCB_IMM;
        w_ctl.alu_ctl = ALU_FUNCT;
      end
      c_st_aluwb: begin
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.reg_write  = 1'b1;
      end
      c_st_jal: begin
        w_ctl.src_a      = SRCA_OLDPC;
        w_ctl.src_b      = SRCB_FOUR;
        w_ctl.alu_ctl    = ALU_ADD;
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.pc_update  = 1'b1;
      end
      c_st_beq: begin
        w_ctl.src_a      = SRCA_RD1;
        w_ctl.src_b      = SRCB_RD2;
        w_ctl.alu_ctl    = ALU_SUB;
        w_ctl.result_src = RES_ALUOUT;
        w_ctl.branch     = 1'b1;
      end
      c_st_trap: w_ctl.trap = 1'b1;
      default:   w_ctl = '0;
    endcase
  end

  // Enables are suppressed during reset and while waiting on memory.
  assign w_gate = ~i_rst & ~w_hold;

  assign o_pc_write   = ((w_ctl.branch & i_zero) | w_ctl.pc_update) & w_gate;
  assign o_ir_write   = w_ctl.ir_write & w_gate;
  assign o_mem_write  = w_ctl.mem_write & w_gate;
  assign o_reg_write  = w_ctl.reg_write & ~i_rst;
  assign o_adr_src    = w_ctl.adr_src;
  assign o_result_src = w_ctl.result_src;
  assign o_alu_src_a  = w_ctl.src_a;
  assign o_alu_src_b  = w_ctl.src_b;
  assign o_alu_ctl    = w_ctl.alu_ctl;
  assign o_trap       = w_ctl.trap;
  assign o_state      = r_state;

  mc_imm_decoder u_imm_decoder (
    .i_op      (i_op),
    .o_imm_src (o_imm_src)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for mc_control_fsm (honours MC_STALL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
`ifdef MC_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       ready;
  logic       o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write, o_trap;
  logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_alu_ctl, o_imm_src;
  logic [3:0] o_state;
  logic [13:0] outs;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         q[$];
  logic [6:0] dir_ops[$];
  logic       ready_plan[$];
  logic [6:0] legal[6] = '{LW, SW, RT, IT, JAL, BEQ};

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_op         (op),
    .i_zero       (zero),
    .i_mem_ready  (ready),
    .o_pc_write   (o_pc_write),
    .o_adr_src    (o_adr_src),
    .o_mem_write  (o_mem_write),
    .o_ir_write   (o_ir_write),
    .o_result_src (o_result_src),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_ctl    (o_alu_ctl),
    .o_imm_src    (o_imm_src),
    .o_reg_write  (o_reg_write),
    .o_trap       (o_trap),
    .o_state      (o_state)
  );

  assign outs = {o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_result_src,
                 o_alu_src_a, o_alu_src_b, o_alu_ctl, o_reg_write, o_trap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control word for a state, from the per-state output table.
  function automatic logic [13:0] exp_out(input int st, input logic z,
                                          input logic rdy, input logic r);
    logic pcw, adr, mw, irw, rw, tr;
    logic [1:0] rs, sa, sb, ac;
    {pcw, adr, mw, irw, rw, tr} = '0;
    {rs, sa, sb, ac} = '0;
    case (st)
      0:  begin irw = rdy; pcw = rdy; sb = 2'b10; rs = 2'b10; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = rdy; end
      6:  begin sa = 2'b10; ac = 2'b10; end
      7:  rw = 1'b1;
      8:  begin sa = 2'b10; sb = 2'b01; ac = 2'b10; end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      10: begin sa = 2'b10; ac = 2'b01; pcw = z; end
      11: tr = 1'b1;
      default: ;
    endcase
    if (r) {pcw, irw, rw, mw} = '0;
    return {pcw, adr, mw, irw, rs, sa, sb, ac, rw, tr};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  // An instruction is a list of visited states; its length is its cycle count.
  task automatic start_instr();
    if (dir_ops.size() > 0) op = dir_ops.pop_front();
    else op = legal[$urandom_range(0, 5)];
    case (op)
      LW:      q = '{0, 1, 2, 3, 4};
      SW:      q = '{0, 1, 2, 5};
      RT:      q = '{0, 1, 6, 7};
      IT:      q = '{0, 1, 8, 7};
      JAL:     q = '{0, 1, 9, 7};
      BEQ:     q = '{0, 1, 10};
      default: q = '{0, 1, 11};
    endcase
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    int   st;
    logic rdy_eff;
    zero  = 1'($urandom_range(0, 1));
    ready = (ready_plan.size() > 0) ? ready_plan.pop_front() : ($urandom_range(0, 3) != 0);
    #1;
    rdy_eff = STALL ? ready : 1'b1;
    st = q[0];
    chk("state", 32'(o_state), st);
    chk("outputs", 32'(outs), 32'(exp_out(st, zero, rdy_eff, 1'b0)));
    chk("imm_src", 32'(o_imm_src), 32'(exp_imm(op)));
    @(posedge clk);
    #1;
    if (st == 11) begin
    end else if (STALL && (st == 0 || st == 3 || st == 5) && !ready) begin
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) start_instr();
    end
    @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks immediate effect, then releases.
  task automatic reset_for(input int n);
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(o_state), 0);
    chk("rst_trap", 32'(o_trap), 0);
    chk("rst_outputs", 32'(outs), 32'(exp_out(0, zero, 1'b1, 1'b1)));
    repeat (n) begin
      @(negedge clk);
      #1;
      chk("rst_hold_state", 32'(o_state), 0);
      chk("rst_hold_outputs", 32'(outs), 32'(exp_out(0, zero, 1'b1, 1'b1)));
    end
    rst = 1'b0;
    q.delete();
    start_instr();
  endtask

  initial begin
    rst   = 1'b1;
    op    = LW;
    zero  = 1'b0;
    ready = 1'b1;
    dir_ops = '{LW, SW, RT, BEQ, BEQ, IT, JAL};
    ready_plan = '{1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    reset_for(3);

    repeat (400) cycle();

    dir_ops.push_back(SW);
    for (int k = 0; k < 100 && q[0] != 5; k++) cycle();
    #1;
    chk("reach_memwrite", 32'(o_state), 5);
    reset_for(1);

    repeat (20) cycle();
    dir_ops.push_back(7'h7F);
    for (int k = 0; k < 100 && q[0] != 11; k++) cycle();
    repeat (12) cycle();
    #1;
    chk("trap_held", 32'(o_trap), 1);
    reset_for(2);

    repeat (150) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
